// File: rtl/call_ret_ctrl_pkg.sv
// Shared types and sizing helpers for the call/return sequencer and its return stack.
package call_ret_ctrl_pkg;

  // Sequencer state: normal operation, or latched after a stack overflow/underflow.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } ctrl_state_t;

  // Bits needed to count 0..entries inclusive (the stack occupancy).
  function automatic int depth_width(input int entries);
    return (entries < 1) ? 1 : $clog2(entries + 1);
  endfunction

  // Bits needed to address one slot of a stack with the given number of entries.
  function automatic int index_width(input int entries);
    return (entries <= 1) ? 1 : $clog2(entries);
  endfunction

endpackage

// File: rtl/call_ret_ctrl_ret_stack.sv
// Parameterised LIFO holding return addresses. Push and pop are ignored when they
// would overflow or underflow, so the caller never corrupts the occupancy count.
module ret_stack
  import call_ret_ctrl_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  localparam int DW   = depth_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  // Storage is rounded up to a power of two so the slot index never needs a range check;
  // slots at or beyond DEPTH are never written because full blocks the push first.
  localparam int AW    = index_width(DEPTH);
  localparam int SLOTS = 1 << AW;

  logic [WIDTH-1:0] mem [SLOTS];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign full   = (depth == DW'(DEPTH));
  assign empty  = (depth == '0);
  assign wr_idx = AW'(depth);
  assign rd_idx = AW'(depth - DW'(1));
  assign top    = empty ? '0 : mem[rd_idx];

  // Occupancy counter and slot array; reset clears both so an empty stack reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem[i] <= '0;
      end
      depth <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      depth       <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/call_ret_ctrl.sv
// Program-counter sequencer: turns decoded call/jump/return/stall requests into the
// PC's jmp/ret controls, maintains the return-address stack, and freezes the PC after
// a stack overflow or underflow until reset.
module call_ret_ctrl
  import call_ret_ctrl_pkg::*;
#(
  parameter int INSTR_ADDR_SIZE = 5,
  parameter int STACK_DEPTH     = 4,
  localparam int DW             = depth_width(STACK_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       call_req,
  input  logic                       jmp_req,
  input  logic                       ret_req,
  input  logic                       cond_ok,
  input  logic                       stall,
  input  logic [INSTR_ADDR_SIZE-1:0] target,
  input  logic [INSTR_ADDR_SIZE-1:0] pc_cur,
  output logic                       pc_jmp,
  output logic [INSTR_ADDR_SIZE-1:0] pc_jmp_addr,
  output logic                       pc_ret,
  output logic [INSTR_ADDR_SIZE-1:0] pc_ret_addr,
  output logic [DW-1:0]              depth,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       fault
);

  localparam logic [INSTR_ADDR_SIZE-1:0] ONE = INSTR_ADDR_SIZE'(1);

  ctrl_state_t                state;
  logic                       push;
  logic                       pop;
  logic                       go_fault;
  logic [INSTR_ADDR_SIZE-1:0] ret_addr_next;

  // Return address wraps naturally at the address width, so the last slot returns to 0.
  assign ret_addr_next = pc_cur + ONE;

  ret_stack #(
    .WIDTH (INSTR_ADDR_SIZE),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr_next),
    .top   (pc_ret_addr),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Zero-latency request decode: stall > call > jmp > ret, with faults holding the PC in place.
  always_comb begin
    pc_jmp      = 1'b0;
    pc_ret      = 1'b0;
    pc_jmp_addr = '0;
    push        = 1'b0;
    pop         = 1'b0;
    go_fault    = 1'b0;
    if (rst) begin
      pc_jmp = 1'b0;
    end else if (state == FAULT) begin
      pc_jmp      = 1'b1;
      pc_jmp_addr = pc_cur;
    end else if (stall) begin
      pc_jmp      = 1'b1;
      pc_jmp_addr = pc_cur;
    end else if (call_req && cond_ok) begin
      pc_jmp = 1'b1;
      if (stk_full) begin
        pc_jmp_addr = pc_cur;
        go_fault    = 1'b1;
      end else begin
        pc_jmp_addr = target;
        push        = 1'b1;
      end
    end else if (jmp_req && cond_ok) begin
      pc_jmp      = 1'b1;
      pc_jmp_addr = target;
    end else if (ret_req) begin
      if (stk_empty) begin
        pc_jmp      = 1'b1;
        pc_jmp_addr = pc_cur;
        go_fault    = 1'b1;
      end else begin
        pc_ret = 1'b1;
        pop    = 1'b1;
      end
    end
  end

  // RUN/FAULT state machine; fault is a registered copy so it only rises after the bad edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fault <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (go_fault) begin
            state <= FAULT;
            fault <= 1'b1;
          end
        end
        FAULT: begin
          state <= FAULT;
          fault <= 1'b1;
        end
        default: begin
          state <= FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

  // The priority chain never selects a jump and a return together.
  assert property (@(posedge clk) !(pc_jmp && pc_ret));

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Self-checking bench for call_ret_ctrl: a queue-based model of the return stack and
// fault latch is compared against the DUT every cycle, and directed steps pin
// hand-computed values from the documented scenarios.
module tb_call_ret_ctrl;

  localparam int N     = 5;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         call_req = 1'b1;
  logic         jmp_req = 1'b0;
  logic         ret_req = 1'b0;
  logic         cond_ok = 1'b1;
  logic         stall = 1'b0;
  logic [N-1:0] target = '0;
  logic [N-1:0] pc_cur = '0;
  logic         pc_jmp;
  logic [N-1:0] pc_jmp_addr;
  logic         pc_ret;
  logic [N-1:0] pc_ret_addr;
  logic [2:0]   depth;
  logic         stk_full;
  logic         stk_empty;
  logic         fault;

  int checks = 0;
  int passes = 0;

  int stk[$];
  bit m_fault = 1'b0;
  bit model_valid = 1'b0;

  call_ret_ctrl #(
    .INSTR_ADDR_SIZE (N),
    .STACK_DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .call_req    (call_req),
    .jmp_req     (jmp_req),
    .ret_req     (ret_req),
    .cond_ok     (cond_ok),
    .stall       (stall),
    .target      (target),
    .pc_cur      (pc_cur),
    .pc_jmp      (pc_jmp),
    .pc_jmp_addr (pc_jmp_addr),
    .pc_ret      (pc_ret),
    .pc_ret_addr (pc_ret_addr),
    .depth       (depth),
    .stk_full    (stk_full),
    .stk_empty   (stk_empty),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of requests just after a rising edge, then return at the falling edge.
  task automatic applyStimulus(input bit r, input bit c, input bit j, input bit rt,
                               input bit co, input bit st, input int tg, input int pc);
    @(posedge clk);
    #1;
    rst      = r;
    call_req = c;
    jmp_req  = j;
    ret_req  = rt;
    cond_ok  = co;
    stall    = st;
    target   = N'(tg);
    pc_cur   = N'(pc);
    @(negedge clk);
  endtask

  // Model state advances on each rising edge from the requests presented during that cycle.
  always @(posedge clk) begin
    if (rst) begin
      stk.delete();
      m_fault     = 1'b0;
      model_valid = 1'b1;
    end else if (!m_fault) begin
      if (stall) begin
        m_fault = m_fault;
      end else if (call_req && cond_ok) begin
        if (stk.size() == DEPTH) m_fault = 1'b1;
        else stk.push_back((int'(pc_cur) + 1) % (1 << N));
      end else if (jmp_req && cond_ok) begin
        m_fault = m_fault;
      end else if (ret_req) begin
        if (stk.size() == 0) m_fault = 1'b1;
        else void'(stk.pop_back());
      end
    end
  end

  // Every falling edge: derive the required outputs from the model and the live requests.
  always @(negedge clk) begin
    int e_jmp;
    int e_ret;
    int e_addr;
    int e_top;
    if (model_valid) begin
      e_jmp  = 0;
      e_ret  = 0;
      e_addr = 0;
      if (rst) begin
        e_jmp = 0;
      end else if (m_fault || stall) begin
        e_jmp  = 1;
        e_addr = pc_cur;
      end else if (call_req && cond_ok) begin
        e_jmp  = 1;
        e_addr = (stk.size() == DEPTH) ? int'(pc_cur) : int'(target);
      end else if (jmp_req && cond_ok) begin
        e_jmp  = 1;
        e_addr = target;
      end else if (ret_req) begin
        if (stk.size() == 0) begin
          e_jmp  = 1;
          e_addr = pc_cur;
        end else begin
          e_ret = 1;
        end
      end
      e_top = (stk.size() == 0) ? 0 : stk[stk.size() - 1];
      checkOutput("pc_jmp", pc_jmp, e_jmp);
      checkOutput("pc_ret", pc_ret, e_ret);
      checkOutput("pc_jmp_addr", pc_jmp_addr, e_addr);
      checkOutput("pc_ret_addr", pc_ret_addr, e_top);
      checkOutput("depth", depth, stk.size());
      checkOutput("stk_full", stk_full, int'(stk.size() == DEPTH));
      checkOutput("stk_empty", stk_empty, int'(stk.size() == 0));
      checkOutput("fault", fault, int'(m_fault));
    end
  end

  initial begin
    // Reset held two cycles with a call pending.
    applyStimulus(1, 1, 0, 0, 1, 0, 9, 3);
    applyStimulus(1, 1, 0, 0, 1, 0, 9, 3);
    checkOutput("rst_depth", depth, 0);
    checkOutput("rst_empty", stk_empty, 1);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_jmp", pc_jmp, 0);
    checkOutput("rst_ret", pc_ret, 0);

    // Call then return.
    applyStimulus(0, 1, 0, 0, 1, 0, 10, 3);
    checkOutput("call_jmp", pc_jmp, 1);
    checkOutput("call_addr", pc_jmp_addr, 10);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 10);
    checkOutput("call_depth", depth, 1);
    checkOutput("call_top", pc_ret_addr, 4);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 12);
    checkOutput("ret_ret", pc_ret, 1);
    checkOutput("ret_top", pc_ret_addr, 4);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 4);
    checkOutput("ret_depth", depth, 0);

    // Fill the stack, then overflow it.
    applyStimulus(0, 1, 0, 0, 1, 0, 5, 1);
    applyStimulus(0, 1, 0, 0, 1, 0, 9, 5);
    applyStimulus(0, 1, 0, 0, 1, 0, 13, 9);
    applyStimulus(0, 1, 0, 0, 1, 0, 20, 13);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 20);
    checkOutput("fill_depth", depth, 4);
    checkOutput("fill_full", stk_full, 1);
    checkOutput("fill_top", pc_ret_addr, 14);
    applyStimulus(0, 1, 0, 0, 1, 0, 3, 20);
    checkOutput("ovf_hold_addr", pc_jmp_addr, 20);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 20);
    checkOutput("ovf_fault", fault, 1);
    checkOutput("ovf_jmp", pc_jmp, 1);
    checkOutput("ovf_addr", pc_jmp_addr, 20);
    checkOutput("ovf_ret_blocked", pc_ret, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 3, 20);
    checkOutput("ovf_depth", depth, 4);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("ovf_cleared", fault, 0);

    // Underflow, then reset while faulted with requests active.
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 7);
    checkOutput("unf_jmp", pc_jmp, 1);
    checkOutput("unf_addr", pc_jmp_addr, 7);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 7);
    checkOutput("unf_fault", fault, 1);
    checkOutput("unf_hold", pc_jmp_addr, 7);
    applyStimulus(1, 1, 0, 1, 1, 0, 4, 7);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 8);
    checkOutput("unf_cleared", fault, 0);
    checkOutput("unf_run_jmp", pc_jmp, 0);

    // Stall beats call; jumps gated by cond_ok; failed call falls through to ret.
    applyStimulus(0, 1, 0, 0, 1, 0, 6, 2);
    applyStimulus(0, 1, 0, 0, 1, 1, 9, 6);
    checkOutput("stall_addr", pc_jmp_addr, 6);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 6);
    checkOutput("stall_depth", depth, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 15, 7);
    checkOutput("jmp_nocond", pc_jmp, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 15, 8);
    checkOutput("jmp_addr", pc_jmp_addr, 15);
    applyStimulus(0, 1, 0, 1, 0, 0, 9, 15);
    checkOutput("fall_ret", pc_ret, 1);
    checkOutput("fall_top", pc_ret_addr, 3);

    // Return address wraps at the top of the address space.
    applyStimulus(0, 1, 0, 0, 1, 0, 2, 31);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 2);
    checkOutput("wrap_depth", depth, 1);
    checkOutput("wrap_top", pc_ret_addr, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 2);
    checkOutput("wrap_ret", pc_ret, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("wrap_empty", stk_empty, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
